// File: rtl/fetch_sequencer_if.sv
// Handshake bundle between fetch_sequencer (master) and the pipeline (slave):
// the DIR/ack_from input handshake and the DOR/ack_to output handshake.
interface fetch_sequencer_if;
    logic        pipe_dir;
    logic [31:0] pipe_data_in;
    logic        pipe_ack_from;
    logic        pipe_dor;
    logic [31:0] pipe_data_out;
    logic        pipe_ack_to;

    modport master (
        output pipe_dir, pipe_data_in, pipe_ack_to,
        input  pipe_ack_from, pipe_dor, pipe_data_out
    );

    modport slave (
        input  pipe_dir, pipe_data_in, pipe_ack_to,
        output pipe_ack_from, pipe_dor, pipe_data_out
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch PC sequencer: issues PCs into the pipeline, retires its results, limits in-flight
// words and flushes stale results on redirect. Define FETCH_SEQ_PERF_EN to build perf counters.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'd0,
    parameter logic [31:0] PC_STEP      = 32'd4,
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    fetch_sequencer_if.master pipe,
    output logic              out_valid,
    output logic [31:0]       out_data,
    output logic [3:0]        inflight,
    output logic [31:0]       perf_issued,
    output logic [31:0]       perf_stall
);
    typedef enum logic [1:0] {IDLE, OFFER, RELEASE} issue_state_t;
    typedef enum logic {WAIT_DOR, ACKED} retire_state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_INFLIGHT);

    issue_state_t  issue_q, issue_d;
    retire_state_t retire_q, retire_d;
    logic [31:0]   pc_q, pc_d;
    logic          dir_d;
    logic [31:0]   data_in_d;
    logic          ack_to_d;
    logic          out_valid_d;
    logic [31:0]   out_data_d;
    logic [3:0]    inflight_d;
    logic [3:0]    discard_q, discard_d;
    logic          accept;
    logic          retire;

    always_comb begin
        issue_d   = issue_q;
        pc_d      = pc_q;
        dir_d     = pipe.pipe_dir;
        data_in_d = pipe.pipe_data_in;
        accept    = 1'b0;
        case (issue_q)
            IDLE: begin
                if (enable && (inflight < MAX_CNT) && !redirect_valid) begin
                    issue_d   = OFFER;
                    dir_d     = 1'b1;
                    data_in_d = pc_q;
                end
            end
            OFFER: begin
                // An ack coincident with a redirect is still a real accept; it just becomes stale.
                if (pipe.pipe_ack_from) begin
                    accept  = 1'b1;
                    dir_d   = 1'b0;
                    pc_d    = pc_q + PC_STEP;
                    issue_d = RELEASE;
                end else if (redirect_valid) begin
                    dir_d   = 1'b0;
                    issue_d = IDLE;
                end
            end
            RELEASE: begin
                if (!pipe.pipe_ack_from) issue_d = IDLE;
            end
            default: issue_d = IDLE;
        endcase
        if (redirect_valid) pc_d = redirect_pc;

        retire_d    = retire_q;
        ack_to_d    = 1'b0;
        out_valid_d = 1'b0;
        out_data_d  = out_data;
        retire      = 1'b0;
        case (retire_q)
            WAIT_DOR: begin
                if (pipe.pipe_dor) begin
                    retire_d = ACKED;
                    ack_to_d = 1'b1;
                    retire   = 1'b1;
                    if (!redirect_valid && (discard_q == 4'd0)) begin
                        out_valid_d = 1'b1;
                        out_data_d  = pipe.pipe_data_out;
                    end
                end
            end
            default: retire_d = WAIT_DOR;
        endcase

        inflight_d = inflight + {3'b000, accept} - {3'b000, retire};
        // Everything still in flight after a redirect belongs to the old stream.
        discard_d = discard_q;
        if (redirect_valid)
            discard_d = inflight_d;
        else if (retire && (discard_q != 4'd0))
            discard_d = discard_q - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            issue_q           <= IDLE;
            retire_q          <= WAIT_DOR;
            pc_q              <= RESET_PC;
            discard_q         <= '0;
            inflight          <= '0;
            pipe.pipe_dir     <= 1'b0;
            pipe.pipe_data_in <= '0;
            pipe.pipe_ack_to  <= 1'b0;
            out_valid         <= 1'b0;
            out_data          <= '0;
        end else begin
            issue_q           <= issue_d;
            retire_q          <= retire_d;
            pc_q              <= pc_d;
            discard_q         <= discard_d;
            inflight          <= inflight_d;
            pipe.pipe_dir     <= dir_d;
            pipe.pipe_data_in <= data_in_d;
            pipe.pipe_ack_to  <= ack_to_d;
            out_valid         <= out_valid_d;
            out_data          <= out_data_d;
        end
    end

`ifdef FETCH_SEQ_PERF_EN
    logic stall;
    assign stall = (issue_q == IDLE) && enable && (inflight == MAX_CNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (accept) perf_issued <= perf_issued + 32'd1;
            if (stall)  perf_stall  <= perf_stall + 32'd1;
        end
    end
`else
    assign perf_issued = '0;
    assign perf_stall  = '0;
`endif
endmodule
